// File: rtl/audio_sched_pkg.sv
// Shared constants for the audio sample scheduler: register offsets, bit positions, FSM states.
package audio_sched_pkg;

    localparam logic [2:0] REG_STATUS     = 3'd0;
    localparam logic [2:0] REG_ACK        = 3'd1;
    localparam logic [2:0] REG_SAMPLE_IDX = 3'd2;
    localparam logic [2:0] REG_CTRL       = 3'd3;
    localparam logic [2:0] REG_WPTR       = 3'd4;
    localparam logic [2:0] REG_RPTR       = 3'd5;
    localparam logic [2:0] REG_DELAY      = 3'd6;
    localparam logic [2:0] REG_OVR_CNT    = 3'd7;

    localparam int STATUS_OVERRUN_BIT = 8;
    localparam int STATUS_ENABLE_BIT  = 9;
    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_CLEAR_BIT     = 1;

    localparam int DELAY_W   = 12;
    localparam int OVR_CNT_W = 16;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        PENDING  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// Simple interconnect slave port (we/addr/wd/rd) shared with the RAM and PIO regions.
interface audio_sample_scheduler_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, addr, wd, input rd);
    modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/audio_sample_scheduler_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge pulse; also suitable for the KEY inputs.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/audio_sample_scheduler.sv
// Paces the audio loop: counts synchronized sample requests, tracks sample index and reverb pointers.
// Optional build macro AUDIO_SCHED_OVR_CNT_EN adds a saturating dropped-edge counter at register 7.
module audio_sample_scheduler
    import audio_sched_pkg::*;
#(
    parameter int SAMPLE_COUNT = 48000,
    parameter int BUF_DEPTH    = 4096,
    parameter int PEND_MAX     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_in,
    audio_sample_scheduler_if.slave   bus,
    output logic                      sample_tick,
    output logic                      overrun
);

    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int IDX_W  = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    sched_state_e         state_q;
    sched_state_e         state_d;
    logic [PEND_W-1:0]    pending;
    logic [IDX_W-1:0]     sample_idx;
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [DELAY_W-1:0]   delay;
    logic [DELAY_W-1:0]   delay_wr;
    logic                 ctrl_en;
    logic                 overrun_q;
    logic                 tick_q;
    logic [31:0]          rd_d;
    logic [31:0]          rd_q;
    logic                 req_rise;

    sync_edge_detect u_req_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (req_in),
        .rise     (req_rise)
    );

    logic [2:0] reg_sel;
    logic       wr_ack;
    logic       wr_ctrl;
    logic       wr_delay;
    logic       clear_req;
    logic       active;
    logic       edge_ok;
    logic       ack_ok;
    logic       accept;
    logic       drop;
    logic       unused_bus;

    assign reg_sel   = bus.addr[4:2];
    assign wr_ack    = bus.we && (reg_sel == REG_ACK);
    assign wr_ctrl   = bus.we && (reg_sel == REG_CTRL);
    assign wr_delay  = bus.we && (reg_sel == REG_DELAY);
    assign clear_req = wr_ctrl && bus.wd[CTRL_CLEAR_BIT];
    assign active    = (state_q != DISABLED);
    assign edge_ok   = active && req_rise;
    assign ack_ok    = active && wr_ack && (pending != '0);
    // A simultaneous ACK frees a slot, so a full counter can still take the edge.
    assign accept    = edge_ok && ((pending < PEND_W'(PEND_MAX)) || ack_ok);
    assign drop      = edge_ok && !accept;
    assign unused_bus = ^{bus.addr[31:5], bus.addr[1:0], bus.wd[31:DELAY_W]};

    assign delay_wr = (32'(bus.wd[DELAY_W-1:0]) > 32'(BUF_DEPTH - 1)) ?
                      DELAY_W'(BUF_DEPTH - 1) : bus.wd[DELAY_W-1:0];
    assign rptr     = wptr - delay[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_en    <= 1'b0;
            delay      <= '0;
            pending    <= '0;
            sample_idx <= '0;
            wptr       <= '0;
            overrun_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= accept && !clear_req;
            if (wr_ctrl) begin
                ctrl_en <= bus.wd[CTRL_ENABLE_BIT];
            end
            if (wr_delay) begin
                delay <= delay_wr;
            end
            if (clear_req) begin
                pending    <= '0;
                sample_idx <= '0;
                wptr       <= '0;
                overrun_q  <= 1'b0;
            end else begin
                if (accept && !ack_ok) begin
                    pending <= pending + PEND_W'(1);
                end else if (ack_ok && !accept) begin
                    pending <= pending - PEND_W'(1);
                end
                if (ack_ok) begin
                    sample_idx <= (sample_idx == IDX_W'(SAMPLE_COUNT - 1)) ?
                                  '0 : sample_idx + IDX_W'(1);
                    wptr       <= wptr + PTR_W'(1);
                end
                if (drop) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

`ifdef AUDIO_SCHED_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_cnt <= '0;
        end else if (clear_req) begin
            ovr_cnt <= '0;
        end else if (drop && (ovr_cnt != '1)) begin
            ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ctrl_en) begin
            state_d = DISABLED;
        end else begin
            unique case (state_q)
                DISABLED: state_d = (pending != '0) ? PENDING : IDLE;
                IDLE: begin
                    if (accept && !clear_req) begin
                        state_d = PENDING;
                    end
                end
                PENDING: begin
                    if (clear_req ||
                        (ack_ok && !accept && (pending == PEND_W'(1)))) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = DISABLED;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_d[PEND_W-1:0]         = pending;
                rd_d[STATUS_OVERRUN_BIT] = overrun_q;
                rd_d[STATUS_ENABLE_BIT]  = ctrl_en;
            end
            REG_SAMPLE_IDX: rd_d = 32'(sample_idx);
            REG_CTRL:       rd_d[CTRL_ENABLE_BIT] = ctrl_en;
            REG_WPTR:       rd_d = 32'(wptr);
            REG_RPTR:       rd_d = 32'(rptr);
            REG_DELAY:      rd_d = 32'(delay);
`ifdef AUDIO_SCHED_OVR_CNT_EN
            REG_OVR_CNT:    rd_d = 32'(ovr_cnt);
`endif
            default:        rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign bus.rd      = rd_q;
    assign sample_tick = tick_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler (small SAMPLE_COUNT/BUF_DEPTH to reach wrap and clamp).
module tb_audio_sample_scheduler;
    import audio_sched_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_in = 1'b0;
    logic sample_tick;
    logic overrun;
    int compared = 0;
    int mismatched = 0;
    int tick_cnt = 0;
    int tick_base;

    audio_sample_scheduler_if bus ();

    audio_sample_scheduler #(
        .SAMPLE_COUNT (4),
        .BUF_DEPTH    (16),
        .PEND_MAX     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .bus         (bus),
        .sample_tick (sample_tick),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_tick === 1'b1) tick_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        compared++;
        if (got !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expected);
        end
    endtask

    task automatic busWrite(input logic [2:0] sel, input logic [31:0] data);
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = {27'd0, sel, 2'b00};
        bus.wd   = data;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    task automatic readCheck(input string tag, input logic [2:0] sel, input logic [31:0] expected);
        @(negedge clk);
        bus.addr = {27'd0, sel, 2'b00};
        @(negedge clk);
        checkOutput(tag, bus.rd, expected);
    endtask

    task automatic pulseReq();
        @(negedge clk);
        req_in = 1'b1;
        repeat (3) @(negedge clk);
        req_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wd = '0;
        repeat (3) @(negedge clk);
        checkOutput("tick_in_reset", 32'(sample_tick), 32'd0);
        checkOutput("overrun_in_reset", 32'(overrun), 32'd0);
        checkOutput("rd_in_reset", bus.rd, 32'd0);
        reset = 1'b1;

        readCheck("status_reset", REG_STATUS, 32'h0);
        readCheck("idx_reset", REG_SAMPLE_IDX, 32'h0);
        readCheck("wptr_reset", REG_WPTR, 32'h0);
        readCheck("ctrl_reset", REG_CTRL, 32'h0);
        checkOutput("fsm_reset", 32'(dut.state_q), 32'(DISABLED));

        pulseReq();
        checkOutput("tick_disabled", 32'(tick_cnt), 32'd0);
        readCheck("status_disabled", REG_STATUS, 32'h0);

        busWrite(REG_CTRL, 32'h1);
        readCheck("status_enabled", REG_STATUS, 32'h200);
        pulseReq();
        checkOutput("tick_single", 32'(tick_cnt), 32'd1);
        readCheck("status_one_pending", REG_STATUS, 32'h201);
        checkOutput("fsm_pending", 32'(dut.state_q), 32'(PENDING));
        busWrite(REG_ACK, 32'h0);
        readCheck("status_after_ack", REG_STATUS, 32'h200);
        readCheck("idx_after_ack", REG_SAMPLE_IDX, 32'h1);
        readCheck("wptr_after_ack", REG_WPTR, 32'h1);
        checkOutput("fsm_idle", 32'(dut.state_q), 32'(IDLE));

        busWrite(REG_ACK, 32'h0);
        readCheck("status_empty_ack", REG_STATUS, 32'h200);
        readCheck("idx_empty_ack", REG_SAMPLE_IDX, 32'h1);
        readCheck("wptr_empty_ack", REG_WPTR, 32'h1);

        @(negedge clk);
        bus.addr = 32'hFFFF_FFE3;
        @(negedge clk);
        checkOutput("status_addr_alias", bus.rd, 32'h200);

        busWrite(REG_DELAY, 32'h2);
        readCheck("delay_two", REG_DELAY, 32'h2);
        readCheck("rptr_wrap", REG_RPTR, 32'hF);
        busWrite(REG_DELAY, 32'hFFF);
        readCheck("delay_clamped", REG_DELAY, 32'hF);
        readCheck("rptr_max_delay", REG_RPTR, 32'h2);
        busWrite(REG_DELAY, 32'h2);

        busWrite(REG_CTRL, 32'h3);
        readCheck("status_clear1", REG_STATUS, 32'h200);
        readCheck("ctrl_clear1", REG_CTRL, 32'h1);
        readCheck("idx_clear1", REG_SAMPLE_IDX, 32'h0);
        readCheck("delay_kept", REG_DELAY, 32'h2);
        readCheck("rptr_after_clear", REG_RPTR, 32'hE);

        for (int i = 0; i < 4; i++) begin
            pulseReq();
            busWrite(REG_ACK, 32'h0);
            readCheck($sformatf("idx_seq%0d", i), REG_SAMPLE_IDX, 32'((i + 1) % 4));
        end
        readCheck("wptr_after_seq", REG_WPTR, 32'h4);

        pulseReq();
        readCheck("status_before_same", REG_STATUS, 32'h201);
        tick_base = tick_cnt;
        @(negedge clk);
        req_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = {27'd0, REG_ACK, 2'b00};
        @(negedge clk);
        bus.we = 1'b0;
        req_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("tick_same_cycle", 32'(tick_cnt), 32'(tick_base + 1));
        readCheck("status_same_cycle", REG_STATUS, 32'h201);
        readCheck("idx_same_cycle", REG_SAMPLE_IDX, 32'h1);
        readCheck("wptr_same_cycle", REG_WPTR, 32'h5);

        busWrite(REG_ACK, 32'h0);
        readCheck("status_drained", REG_STATUS, 32'h200);
        tick_base = tick_cnt;
        repeat (5) pulseReq();
        readCheck("status_overrun", REG_STATUS, 32'h303);
        checkOutput("overrun_pin", 32'(overrun), 32'd1);
        checkOutput("tick_overrun", 32'(tick_cnt), 32'(tick_base + 3));
`ifdef AUDIO_SCHED_OVR_CNT_EN
        readCheck("ovr_cnt", REG_OVR_CNT, 32'h2);
`else
        readCheck("ovr_cnt", REG_OVR_CNT, 32'h0);
`endif
        busWrite(REG_ACK, 32'h0);
        readCheck("status_two_sticky", REG_STATUS, 32'h302);
        readCheck("idx_before_clear", REG_SAMPLE_IDX, 32'h3);

        busWrite(REG_CTRL, 32'h3);
        readCheck("status_clear2", REG_STATUS, 32'h200);
        readCheck("ctrl_clear2", REG_CTRL, 32'h1);
        readCheck("idx_clear2", REG_SAMPLE_IDX, 32'h0);
        readCheck("wptr_clear2", REG_WPTR, 32'h0);
        readCheck("ovr_cnt_clear", REG_OVR_CNT, 32'h0);
        checkOutput("overrun_pin_clear", 32'(overrun), 32'd0);

        busWrite(REG_CTRL, 32'h0);
        readCheck("status_disable", REG_STATUS, 32'h0);
        tick_base = tick_cnt;
        pulseReq();
        checkOutput("tick_redisabled", 32'(tick_cnt), 32'(tick_base));
        readCheck("status_redisabled", REG_STATUS, 32'h0);
        readCheck("ack_reads_zero", REG_ACK, 32'h0);

        busWrite(REG_CTRL, 32'h1);
        pulseReq();
        readCheck("status_before_reset", REG_STATUS, 32'h201);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        readCheck("status_mid_reset", REG_STATUS, 32'h0);
        readCheck("delay_mid_reset", REG_DELAY, 32'h0);
        checkOutput("fsm_mid_reset", 32'(dut.state_q), 32'(DISABLED));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
